// File: rtl/npc_ctrl.sv
// Multi-cycle sequencer for the NPC core: owns pc/inst, runs the fetch and
// load/store handshakes, and gates rf/pc updates so one instruction executes at a time.
module npc_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        ifu_req_valid,
  input  logic        ifu_req_ready,
  output logic [31:0] ifu_req_addr,
  input  logic        ifu_resp_valid,
  input  logic [31:0] ifu_resp_data,
  output logic [31:0] inst,
  output logic [31:0] pc,
  input  logic        dec_dram_en,
  input  logic        dec_dram_wen,
  input  logic        dec_rf_wen,
  input  logic        dec_ebreak,
  input  logic [31:0] next_pc,
  output logic        lsu_req_valid,
  output logic        lsu_req_wen,
  input  logic        lsu_req_ready,
  input  logic        lsu_resp_valid,
  output logic        rf_wen,
  output logic        retire,
  output logic [63:0] instret,
  output logic        halted,
  output logic        err
);

  localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  typedef enum logic [2:0] {
    IDLE, IF_REQ, IF_WAIT, EXEC, MEM_REQ, MEM_WAIT, WB, HALT
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] phase_cnt;
  logic             in_phase;
  logic             phase_done;
  logic             timeout_hit;

  // A phase spans REQ plus WAIT; the step that advances the phase beats the timeout.
  always_comb begin
    in_phase   = state inside {IF_REQ, IF_WAIT, MEM_REQ, MEM_WAIT};
    phase_done = 1'b0;
    case (state)
      IF_REQ:   phase_done = ifu_req_ready;
      IF_WAIT:  phase_done = ifu_resp_valid;
      MEM_REQ:  phase_done = lsu_req_ready;
      MEM_WAIT: phase_done = lsu_resp_valid;
      default:  phase_done = 1'b0;
    endcase
    timeout_hit = (TIMEOUT != 0) && in_phase && !phase_done &&
                  ((32'(phase_cnt) + 32'd1) >= TIMEOUT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     state_nxt = IF_REQ;
      IF_REQ:   if (ifu_req_ready)  state_nxt = IF_WAIT;
      IF_WAIT:  if (ifu_resp_valid) state_nxt = EXEC;
      EXEC: begin
        if (dec_ebreak)       state_nxt = HALT;
        else if (dec_dram_en) state_nxt = MEM_REQ;
        else                  state_nxt = WB;
      end
      MEM_REQ:  if (lsu_req_ready)  state_nxt = MEM_WAIT;
      MEM_WAIT: if (lsu_resp_valid) state_nxt = WB;
      WB:       state_nxt = IF_REQ;
      HALT:     state_nxt = HALT;
      default:  state_nxt = IDLE;
    endcase
    if (timeout_hit) state_nxt = HALT;
  end

  always_comb begin
    ifu_req_valid = (state == IF_REQ);
    lsu_req_valid = (state == MEM_REQ);
    lsu_req_wen   = (state == MEM_REQ) && dec_dram_wen;
    rf_wen        = (state == WB) && dec_rf_wen;
    retire        = (state == WB) || ((state == EXEC) && dec_ebreak);
    halted        = (state == HALT);
  end

  assign ifu_req_addr = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc        <= RESET_PC;
      inst      <= NOP;
      instret   <= 64'd0;
      err       <= 1'b0;
      phase_cnt <= '0;
    end else begin
      if (state == IF_WAIT && ifu_resp_valid) inst <= ifu_resp_data;
      if (state == WB) pc <= next_pc;
      if (retire) instret <= instret + 64'd1;
      if (timeout_hit) err <= 1'b1;
      // Counter is zero outside a phase, so every REQ entry starts from zero.
      if (!in_phase)
        phase_cnt <= '0;
      else if (phase_cnt != {CNT_W{1'b1}})
        phase_cnt <= phase_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_npc_ctrl.sv
// Directed bench for npc_ctrl: an instruction-level timeline model drives the
// memories/decoder and predicts every output cycle by cycle.
module tb_npc_ctrl;
  localparam logic [31:0] RPC = 32'h8000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int TO = 8;
  localparam int K_ALU = 0, K_LD = 1, K_ST = 2, K_EBRK = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid;
  logic [31:0] ifu_req_addr, ifu_resp_data, inst, pc, next_pc;
  logic        dec_dram_en, dec_dram_wen, dec_rf_wen, dec_ebreak;
  logic        lsu_req_valid, lsu_req_wen, lsu_req_ready, lsu_resp_valid;
  logic        rf_wen, retire, halted, err;
  logic [63:0] instret;

  npc_ctrl #(.RESET_PC(RPC), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
    .ifu_req_addr(ifu_req_addr), .ifu_resp_valid(ifu_resp_valid),
    .ifu_resp_data(ifu_resp_data), .inst(inst), .pc(pc),
    .dec_dram_en(dec_dram_en), .dec_dram_wen(dec_dram_wen),
    .dec_rf_wen(dec_rf_wen), .dec_ebreak(dec_ebreak), .next_pc(next_pc),
    .lsu_req_valid(lsu_req_valid), .lsu_req_wen(lsu_req_wen),
    .lsu_req_ready(lsu_req_ready), .lsu_resp_valid(lsu_resp_valid),
    .rf_wen(rf_wen), .retire(retire), .instret(instret),
    .halted(halted), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ifu_ready, ifu_rvalid;
    logic [31:0] ifu_rdata;
    logic        d_en, d_wen, d_rfw, d_ebrk;
    logic [31:0] d_npc;
    logic        lsu_ready, lsu_rvalid;
    logic        e_ifu_valid, e_lsu_valid, e_lsu_wen, e_rf_wen, e_retire;
    logic        e_halted, e_err;
    logic [31:0] e_pc, e_inst;
    logic [63:0] e_instret;
  } cyc_t;

  cyc_t        tl[$];
  cyc_t        ce;
  logic [31:0] m_pc, m_inst;
  logic [63:0] m_instret;
  logic        m_halted, m_err;
  int          n_chk = 0, n_fail = 0;
  int          cur = 0;
  bit          chk_en = 1'b0;
  int          ret_q[$];
  int          rfw_q[$];
  logic [31:0] fa_q[$];
  int          halt_cyc;
  logic        prev_ifv;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d got=%0h want=%0h", nm, cur, act, exp);
    end
  endtask

  function automatic cyc_t blank();
    cyc_t r;
    r = '{default: '0};
    return r;
  endfunction

  function automatic cyc_t with_dec(input cyc_t r_in, input int kind, input logic rfw,
                                    input logic [31:0] npc);
    cyc_t r;
    r        = r_in;
    r.d_en   = (kind == K_LD) || (kind == K_ST);
    r.d_wen  = (kind == K_ST);
    r.d_rfw  = rfw;
    r.d_ebrk = (kind == K_EBRK);
    r.d_npc  = npc;
    return r;
  endfunction

  task automatic emit(input cyc_t r_in);
    cyc_t r;
    r           = r_in;
    r.e_pc      = m_pc;
    r.e_inst    = m_inst;
    r.e_instret = m_instret;
    r.e_halted  = m_halted;
    r.e_err     = m_err;
    tl.push_back(r);
  endtask

  task automatic model_reset();
    tl.delete();
    m_pc = RPC; m_inst = NOP; m_instret = 64'd0; m_halted = 1'b0; m_err = 1'b0;
    emit(blank());
  endtask

  task automatic add_idle(input int k);
    for (int i = 0; i < k; i++) emit(blank());
  endtask

  // ir/mr: cycles request waits for ready; iw/mw: idle cycles before the response.
  task automatic add_instr(input int kind, input logic [31:0] word, input logic rfw,
                           input logic [31:0] npc, input int ir, input int iw,
                           input int mr, input int mw, input bit noise);
    cyc_t r;
    int   n;
    if (m_halted) return;
    n = 0;
    for (int i = 0; i <= ir; i++) begin
      r = blank();
      r.e_ifu_valid = 1'b1;
      r.ifu_ready   = (i == ir);
      if (noise) begin r.ifu_rvalid = 1'b1; r.ifu_rdata = 32'hdead_beef; end
      emit(r); n++;
      if (i != ir && n >= TO) begin m_halted = 1'b1; m_err = 1'b1; return; end
    end
    for (int i = 0; i <= iw; i++) begin
      r = blank();
      r.ifu_rvalid = (i == iw);
      r.ifu_rdata  = (i == iw) ? word : 32'h0;
      emit(r); n++;
      if (i == iw) m_inst = word;
      else if (n >= TO) begin m_halted = 1'b1; m_err = 1'b1; return; end
    end
    r = with_dec(blank(), kind, rfw, npc);
    if (noise) begin r.ifu_rvalid = 1'b1; r.ifu_rdata = 32'h0bad_0bad; end
    if (kind == K_EBRK) begin
      r.e_retire = 1'b1; emit(r); m_instret++; m_halted = 1'b1; return;
    end
    emit(r);
    if (kind == K_LD || kind == K_ST) begin
      n = 0;
      for (int i = 0; i <= mr; i++) begin
        r = with_dec(blank(), kind, rfw, npc);
        r.e_lsu_valid = 1'b1;
        r.e_lsu_wen   = (kind == K_ST);
        r.lsu_ready   = (i == mr);
        if (noise) r.lsu_rvalid = 1'b1;
        emit(r); n++;
        if (i != mr && n >= TO) begin m_halted = 1'b1; m_err = 1'b1; return; end
      end
      for (int i = 0; i <= mw; i++) begin
        r = with_dec(blank(), kind, rfw, npc);
        r.lsu_rvalid = (i == mw);
        emit(r); n++;
        if (i != mw && n >= TO) begin m_halted = 1'b1; m_err = 1'b1; return; end
      end
    end
    r = with_dec(blank(), kind, rfw, npc);
    r.e_rf_wen = rfw;
    r.e_retire = 1'b1;
    emit(r);
    m_pc = npc;
    m_instret++;
  endtask

  task automatic apply(input cyc_t r);
    ifu_req_ready  = r.ifu_ready;
    ifu_resp_valid = r.ifu_rvalid;
    ifu_resp_data  = r.ifu_rdata;
    dec_dram_en    = r.d_en;
    dec_dram_wen   = r.d_wen;
    dec_rf_wen     = r.d_rfw;
    dec_ebreak     = r.d_ebrk;
    next_pc        = r.d_npc;
    lsu_req_ready  = r.lsu_ready;
    lsu_resp_valid = r.lsu_rvalid;
  endtask

  task automatic run(input int ncyc);
    ret_q.delete(); rfw_q.delete(); fa_q.delete();
    halt_cyc = -1; prev_ifv = 1'b0;
    rst_n = 1'b0;
    apply(blank());
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", pc, RPC);
    chk("rst_inst", inst, NOP);
    chk("rst_instret", instret, 64'd0);
    chk("rst_halted", halted, 0);
    chk("rst_err", err, 0);
    chk("rst_ifu_valid", ifu_req_valid, 0);
    rst_n = 1'b1;
    for (int c = 0; c < ncyc; c++) begin
      apply(tl[c]);
      cur = c;
      chk_en = 1'b1;
      @(posedge clk);
      #1;
    end
    chk_en = 1'b0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      ce = tl[cur];
      chk("ifu_req_valid", ifu_req_valid, ce.e_ifu_valid);
      chk("ifu_req_addr", ifu_req_addr, ce.e_pc);
      chk("pc", pc, ce.e_pc);
      chk("inst", inst, ce.e_inst);
      chk("lsu_req_valid", lsu_req_valid, ce.e_lsu_valid);
      chk("lsu_req_wen", lsu_req_wen, ce.e_lsu_wen);
      chk("rf_wen", rf_wen, ce.e_rf_wen);
      chk("retire", retire, ce.e_retire);
      chk("instret", instret, ce.e_instret);
      chk("halted", halted, ce.e_halted);
      chk("err", err, ce.e_err);
      if (retire) ret_q.push_back(cur);
      if (rf_wen) rfw_q.push_back(cur);
      if (ifu_req_valid && !prev_ifv) fa_q.push_back(ifu_req_addr);
      if (halted && halt_cyc < 0) halt_cyc = cur;
      prev_ifv = ifu_req_valid;
    end
  end

  initial begin
    int ret_exp[9];
    ret_exp = '{4, 8, 12, 21, 32, 39, 43, 53, 56};

    // Run 1: addi stream, backpressure, lw, sw, taken branch, 8-cycle fetch, ebreak.
    model_reset();
    add_instr(K_ALU, 32'h0010_0093, 1'b1, m_pc + 4, 0, 0, 0, 0, 1'b0);
    add_instr(K_ALU, 32'h0020_0113, 1'b1, m_pc + 4, 0, 0, 0, 0, 1'b0);
    add_instr(K_ALU, 32'h0030_0193, 1'b1, m_pc + 4, 0, 0, 0, 0, 1'b0);
    add_instr(K_ALU, 32'h0020_8213, 1'b1, m_pc + 4, 5, 0, 0, 0, 1'b1);
    add_instr(K_LD,  32'h0000_a283, 1'b1, m_pc + 4, 0, 0, 2, 3, 1'b1);
    add_instr(K_ST,  32'h0030_a223, 1'b0, m_pc + 4, 0, 0, 0, 1, 1'b0);
    add_instr(K_ALU, 32'h0e00_0463, 1'b0, 32'h8000_0100, 0, 0, 0, 0, 1'b0);
    add_instr(K_ALU, 32'h0050_0313, 1'b1, m_pc + 4, 0, 6, 0, 0, 1'b0);
    add_instr(K_EBRK, 32'h0010_0073, 1'b0, 32'h0, 0, 0, 0, 0, 1'b0);
    add_idle(6);
    run(tl.size());
    chk("retire_count", ret_q.size(), 9);
    for (int i = 0; i < 9 && i < ret_q.size(); i++) chk("retire_cycle", ret_q[i], ret_exp[i]);
    if (ret_q.size() >= 5) chk("lw_latency", ret_q[4] - ret_q[3], 11);
    if (fa_q.size() >= 1) chk("first_fetch_addr", fa_q[0], 32'h8000_0000);
    if (fa_q.size() >= 8) chk("branch_fetch_addr", fa_q[7], 32'h8000_0100);
    chk("rf_wen_count", rfw_q.size(), 6);
    if (rfw_q.size() >= 5) chk("lw_rf_wen_cycle", rfw_q[4], 32);
    chk("final_pc", pc, 32'h8000_0104);
    chk("final_instret", instret, 64'd9);
    chk("final_halted", halted, 1);
    chk("final_err", err, 0);

    // Run 2: fetch response never arrives -> timeout halt.
    model_reset();
    add_instr(K_ALU, 32'h0010_0093, 1'b1, m_pc + 4, 0, 0, 0, 0, 1'b0);
    add_instr(K_ALU, 32'h0020_0113, 1'b1, m_pc + 4, 0, 100, 0, 0, 1'b0);
    add_idle(5);
    run(tl.size());
    chk("timeout_halt_cycle", halt_cyc, 13);
    chk("timeout_err", err, 1);
    chk("timeout_instret", instret, 64'd1);
    chk("timeout_ifu_valid", ifu_req_valid, 0);

    // Run 3: asynchronous reset while a load waits for its response.
    model_reset();
    add_instr(K_ALU, 32'h0010_0093, 1'b1, m_pc + 4, 0, 0, 0, 0, 1'b0);
    add_instr(K_LD,  32'h0000_a283, 1'b1, m_pc + 4, 0, 0, 0, 100, 1'b0);
    run(11);
    chk("pre_rst_pc", pc, 32'h8000_0004);
    chk("pre_rst_instret", instret, 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_pc", pc, RPC);
    chk("arst_inst", inst, NOP);
    chk("arst_instret", instret, 64'd0);
    chk("arst_lsu_valid", lsu_req_valid, 0);
    chk("arst_ifu_valid", ifu_req_valid, 0);
    chk("arst_retire", retire, 0);
    chk("arst_halted", halted, 0);
    chk("arst_err", err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
